// File: rtl/imem_program_loader.sv
// Boot loader: collects a length-prefixed, XOR-checksummed byte stream into 32-bit words,
// writes them to instruction memory and releases the core only after a clean load.
module imem_program_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              error
);
    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, WRITE, CSUM, DONE, ERROR} state_t;

    localparam logic [16:0] CAP = 17'(1) << ADDR_W;

    state_t            state, state_nxt;
    logic [15:0]       len;
    logic [7:0]        csum;
    logic [1:0]        byte_cnt;
    logic [ADDR_W:0]   word_cnt;
    logic [31:0]       word;
    logic [16:0]       n_full;
    logic              last_word;

    // Full word count as seen while the high length byte is on the bus.
    assign n_full    = {1'b0, in_data, len[7:0]};
    assign last_word = (32'(word_cnt) + 32'd1) == 32'(len);

    assign imem_addr  = word_cnt[ADDR_W-1:0];
    assign imem_wdata = word;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        imem_we   = 1'b0;
        busy      = 1'b1;
        cpu_rst   = 1'b1;
        done      = 1'b0;
        error     = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = LEN0;
            end
            LEN0: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = LEN1;
            end
            LEN1: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (n_full == 17'd0)  state_nxt = CSUM;
                    else if (n_full > CAP) state_nxt = ERROR;
                    else                   state_nxt = DATA;
                end
            end
            DATA: begin
                in_ready = 1'b1;
                if (in_valid && byte_cnt == 2'd3) state_nxt = WRITE;
            end
            WRITE: begin
                imem_we   = 1'b1;
                state_nxt = last_word ? CSUM : DATA;
            end
            CSUM: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = (in_data == csum) ? DONE : ERROR;
            end
            DONE: begin
                busy    = 1'b0;
                cpu_rst = 1'b0;
                done    = 1'b1;
                if (start) state_nxt = LEN0;
            end
            ERROR: begin
                busy  = 1'b0;
                error = 1'b1;
                if (start) state_nxt = LEN0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len      <= '0;
            csum     <= '0;
            byte_cnt <= '0;
            word_cnt <= '0;
            word     <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        csum     <= '0;
                        byte_cnt <= '0;
                        word_cnt <= '0;
                    end
                end
                LEN0: begin
                    if (in_valid) begin
                        len[7:0] <= in_data;
                        csum     <= csum ^ in_data;
                    end
                end
                LEN1: begin
                    if (in_valid) begin
                        len[15:8] <= in_data;
                        csum      <= csum ^ in_data;
                    end
                end
                DATA: begin
                    if (in_valid) begin
                        word[8*byte_cnt +: 8] <= in_data;
                        byte_cnt              <= byte_cnt + 2'd1;
                        csum                  <= csum ^ in_data;
                    end
                end
                WRITE: word_cnt <= word_cnt + 1'b1;
                default: ;
            endcase
        end
    end
endmodule
